bus_mem_slave: RTL and testbench

Memory-mapped responder for the core's simple single-outstanding bus: it answers the requests driven onto `bus_en / wr_en / addr / wr_data / byte_en` with a one-cycle `ack` and read data. It backs a word-addressed on-chip RAM with per-byte write enables and an optional programmable wait-state delay. It sits on the bus fabric opposite the core's bus master, serving as boot/scratchpad memory.

---
 rtl/arvi_bus_pkg.sv | 27 ++
 rtl/bus_sram_bank.sv | 30 +++
 rtl/bus_mem_slave.sv | 135 +++++++++++++
 tb/tb_bus_mem_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arvi_bus_pkg.sv
// Shared definitions for the arvi simple bus: slave FSM states, request bundle, widths.
package arvi_bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } slv_state_e;

  typedef struct packed {
    logic                  wr_en;
    logic [31:0]           addr;
    logic [BUS_DATA_W-1:0] wr_data;
    logic [BUS_BE_W-1:0]   byte_en;
  } bus_req_t;

  // 33-bit compare so a window ending exactly at 2^32 still decodes correctly.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [32:0] limit);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/bus_sram_bank.sv
// Word array with per-byte write enables; writes on the rising clock edge,
// read port follows the (registered) index supplied by the slave.
module bus_sram_bank
  import arvi_bus_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [BUS_BE_W-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [BUS_DATA_W-1:0]    wdata,
  output logic [BUS_DATA_W-1:0]    rdata
);

  logic [BUS_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BUS_BE_W; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/bus_mem_slave.sv
// Bus memory responder: latches a request, optionally waits, then acks for one cycle.
// Build option ARVI_BUS_WAIT_EN enables the WAIT_STATES counter (otherwise W=0).
module bus_mem_slave
  import arvi_bus_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_bus_en,
  input  logic                  i_wr_en,
  input  logic [31:0]           i_addr,
  input  logic [BUS_DATA_W-1:0] i_wr_data,
  input  logic [BUS_BE_W-1:0]   i_byte_en,
  output logic                  o_ack,
  output logic [BUS_DATA_W-1:0] o_rd_data
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_cfg
    $error("bus_mem_slave: illegal DEPTH or WAIT_STATES");
  end

  slv_state_e            state_q, state_d;
  bus_req_t              req_q, req_d;
  logic                  ack_q, ack_d;
  logic [BUS_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                  hit;
  logic                  mem_we;
  logic                  cnt_zero;
  logic [BUS_DATA_W-1:0] bank_rdata;

`ifdef ARVI_BUS_WAIT_EN
  localparam logic [3:0] WAIT_CFG = 4'(WAIT_STATES);
  logic [3:0] cnt_q, cnt_d;

  assign cnt_zero = (cnt_q == 4'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && i_bus_en) begin
      cnt_d = WAIT_CFG;
    end else if (state_q == WAIT && i_bus_en && !cnt_zero) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign cnt_zero = 1'b1;
`endif

  assign hit = addr_in_window(req_q.addr, BASE_ADDR, LIMIT);

  // An abort in WAIT takes priority over the counter; ACK ignores bus_en entirely.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    ack_d     = 1'b0;
    rd_data_d = 32'h0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_bus_en) begin
          req_d.wr_en   = i_wr_en;
          req_d.addr    = i_addr;
          req_d.wr_data = i_wr_data;
          req_d.byte_en = i_byte_en;
          state_d       = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!i_bus_en) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          mem_we    = req_q.wr_en && hit;
          ack_d     = 1'b1;
          rd_data_d = (!req_q.wr_en && hit) ? bank_rdata : 32'h0;
          state_d   = ACK;
        end else begin
          state_d = WAIT;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      ack_q     <= 1'b0;
      rd_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  bus_sram_bank #(
    .DEPTH(DEPTH)
  ) u_bank (
    .clk  (i_clk),
    .we   (mem_we),
    .be   (req_q.byte_en),
    .idx  (req_q.addr[AW+1:2]),
    .wdata(req_q.wr_data),
    .rdata(bank_rdata)
  );

  assign o_ack     = ack_q;
  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Scoreboard bench for bus_mem_slave: the driver queues expected ack data and ack cycle,
// a negedge monitor pops and compares whenever o_ack is seen.
module tb_bus_mem_slave;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef ARVI_BUS_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  byte_en = 4'h0;
  logic        o_ack;
  logic [31:0] o_rd_data;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  bus_mem_slave #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .WAIT_STATES(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_bus_en(bus_en),
    .i_wr_en(wr_en),
    .i_addr(addr),
    .i_wr_data(wr_data),
    .i_byte_en(byte_en),
    .o_ack(o_ack),
    .o_rd_data(o_rd_data)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Monitor: every ack must match the head of the queue; outside ack, rd_data must be zero.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (o_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ack_data", o_rd_data, e.data);
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("idle_rd_data", o_rd_data, 32'h0);
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp_rd, input bit track);
    exp_t e;
    bus_en  = 1'b1;
    wr_en   = wr;
    addr    = a;
    wr_data = d;
    byte_en = be;
    if (track) begin
      e.data = wr ? 32'h0 : exp_rd;
      e.cyc  = cyc + 2 + W;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ack(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (o_ack === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL %s: no ack within 40 cycles (got 0, expected 1)", name);
    end
  endtask

  // Full transfer with the minimum-spacing master: drop bus_en right after ack, re-issue one cycle later.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp_rd, input string name);
    issue(wr, a, d, be, exp_rd, 1'b1);
    wait_ack(name);
    bus_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(o_ack), 32'h0);
    chk("reset_rd_data", o_rd_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read
    xfer(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "wr_deadbeef");
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, "rd_deadbeef");

    // Partial write; read ignores byte_en
    xfer(1'b1, BASE + 32'h20, 32'h11223344, 4'hF, 32'h0, "wr_full");
    xfer(1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, "wr_partial");
    xfer(1'b0, BASE + 32'h20, 32'h0, 4'h0, 32'h11BB33DD, "rd_partial");

    // byte_en=0 write is acked but changes nothing
    xfer(1'b1, BASE + 32'h10, 32'h0, 4'h0, 32'h0, "wr_be0");
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, "rd_after_be0");

    // Out of range on both sides; aliased word indices must stay untouched
    xfer(1'b1, BASE, 32'h12345678, 4'hF, 32'h0, "wr_word0");
    xfer(1'b1, BASE + 32'hFC, 32'hCAFEF00D, 4'hF, 32'h0, "wr_word63");
    xfer(1'b1, BASE + 32'h100, 32'h00000055, 4'hF, 32'h0, "wr_oor_high");
    xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, 32'h0, "rd_oor_high");
    xfer(1'b1, BASE - 32'h4, 32'hFFFFFFFF, 4'hF, 32'h0, "wr_oor_low");
    xfer(1'b0, BASE - 32'h4, 32'h0, 4'hF, 32'h0, "rd_oor_low");
    xfer(1'b0, BASE, 32'h0, 4'hF, 32'h12345678, "rd_word0");
    xfer(1'b0, BASE + 32'hFC, 32'h0, 4'hF, 32'hCAFEF00D, "rd_word63");

    // Abort in WAIT: no ack, no write
    issue(1'b1, BASE + 32'h10, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    bus_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, "rd_after_abort");

    // Reset during WAIT: write discarded, FSM back to IDLE
    issue(1'b1, BASE + 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    bus_en = 1'b0;
    #1;
    chk("rst_wait_ack", 32'(o_ack), 32'h0);
    chk("rst_wait_rd", o_rd_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, 32'h11BB33DD, "rd_after_rst_wait");

    // Reset during ACK clears outputs asynchronously
    issue(1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'h0, 1'b0);
    wait_ack("rd_before_rst_ack");
    chk("pre_rst_rd", o_rd_data, 32'hDEADBEEF);
    rst_n  = 1'b0;
    bus_en = 1'b0;
    #1;
    chk("rst_ack_ack", 32'(o_ack), 32'h0);
    chk("rst_ack_rd", o_rd_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: 8 writes then 8 reads at words 0..7, spacing enforced by ack_cycle
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, BASE + 32'(4 * i), {8'(i), 8'hA5, 8'(i + 16), 8'h5A}, 4'hF, 32'h0, "b2b_wr");
    end
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, {8'(i), 8'hA5, 8'(i + 16), 8'h5A}, "b2b_rd");
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
